// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button debounce block.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // One counter serves both debounce and long-press timing, so size it for the larger.
  function automatic int cnt_width(input int debounce_cycles, input int long_cycles);
    int max_cycles;
    max_cycles = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-FF synchroniser, polarity normalisation, debounce FSM,
// long-press timer and registered level/pulse outputs.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int                CNT_W     = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic              RAW_IDLE  = ACTIVE_LOW;

  logic             sync1_reg, sync2_reg;
  logic             sync;
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             long_done_reg, long_done_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             long_reg, long_next;

  assign sync    = sync2_reg ^ ACTIVE_LOW;
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    long_done_next = long_done_reg;
    level_next     = level_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    long_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_next = IDLE;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (!long_done_reg) begin
          if (cnt_reg == LONG_LAST) begin
            long_next      = 1'b1;
            long_done_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed keeps long_done so one press yields one long pulse.
        if (sync) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next     = IDLE;
          level_next     = 1'b0;
          release_next   = 1'b1;
          long_done_next = 1'b0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_reg     <= RAW_IDLE;
      sync2_reg     <= RAW_IDLE;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      long_done_reg <= 1'b0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
    end else begin
      sync1_reg     <= raw;
      sync2_reg     <= sync1_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      long_done_reg <= long_done_next;
      level_reg     <= level_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      long_reg      <= long_next;
    end
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner feeding the button PIO; each channel
// is an independent debounce_ch instance on the shared clock.
module button_debounce
  import button_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_long
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw           (btn_raw[gi]),
      .level         (btn_level[gi]),
      .press_pulse   (btn_press[gi]),
      .release_pulse (btn_release[gi]),
      .long_pulse    (btn_long[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: table vectors, directed corner
// sequences and random stimulus against a run-length/timestamp reference model.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [3:0] btn_raw = 4'b1111;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_clk = ~clk_clk;

  button_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_long      (btn_long)
  );

  // Reference model: sync is the pressed value seen two edges earlier; a level
  // change needs D+1 consecutive disagreeing samples; long fires L edges after
  // the hold began (acceptance, or the edge after the last released sample).
  logic [3:0] hist[$];
  logic       m_prev_rst_n = 1'b0;
  logic [3:0] exp_level = '0, exp_press = '0, exp_release = '0, exp_long = '0;
  logic [3:0] m_long_done = '0;
  int         m_run[4];
  int         m_hold[4];
  int         t = 0;

  function automatic void model_edge(input logic [3:0] raw, input logic rst_n);
    logic [3:0] sync;
    logic       s;
    sync = '0;
    if (m_prev_rst_n && hist.size() >= 2) sync = hist[hist.size()-2];
    hist.push_back(rst_n ? ~raw : 4'b0000);
    if (hist.size() > 3) void'(hist.pop_front());
    m_prev_rst_n = rst_n;
    exp_press = '0; exp_release = '0; exp_long = '0;
    for (int ch = 0; ch < 4; ch++) begin
      s = sync[ch];
      if (!rst_n) begin
        exp_level[ch] = 1'b0; m_run[ch] = 0; m_long_done[ch] = 1'b0;
      end else begin
        m_run[ch] = (s != exp_level[ch]) ? m_run[ch] + 1 : 0;
        if (m_run[ch] == D + 1) begin
          exp_level[ch] = ~exp_level[ch];
          m_run[ch] = 0;
          m_long_done[ch] = 1'b0;
          if (exp_level[ch]) begin
            exp_press[ch] = 1'b1; m_hold[ch] = t;
          end else begin
            exp_release[ch] = 1'b1;
          end
        end else if (exp_level[ch]) begin
          if (!s) m_hold[ch] = t + 1;
          else if (!m_long_done[ch] && (t - m_hold[ch] == L)) begin
            exp_long[ch] = 1'b1; m_long_done[ch] = 1'b1;
          end
        end
      end
    end
    t++;
  endfunction

  task automatic step(input logic [3:0] raw, input logic rst_n);
    btn_raw = raw;
    reset_reset_n = rst_n;
    @(posedge clk_clk);
    model_edge(raw, rst_n);
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
      n_fail++;
      $display("FAIL model edge=%0d got lvl=%b prs=%b rel=%b lng=%b required lvl=%b prs=%b rel=%b lng=%b",
               t, btn_level, btn_press, btn_release, btn_long, exp_level, exp_press, exp_release, exp_long);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] raw;
    logic       rst_n;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int press_edge, long_edge, long_cnt, rel_edge, press_cnt, rel_cnt, seen, early;
    logic [3:0] rnd_raw;

    // Rows 0-2 reset, 3-4 first cycles out of reset, 5-10 released, 11-19 clean press on ch0.
    for (int i = 0; i < 20; i++) begin
      tbl[i].raw   = (i < 5) ? 4'b0000 : ((i < 11) ? 4'b1111 : 4'b1110);
      tbl[i].rst_n = (i >= 3);
      tbl[i].level = (i >= 17) ? 4'b0001 : 4'b0000;
      tbl[i].press = (i == 17) ? 4'b0001 : 4'b0000;
      tbl[i].rel   = 4'b0000;
      tbl[i].lng   = 4'b0000;
    end
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].raw, tbl[i].rst_n);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {tbl[i].level, tbl[i].press, tbl[i].rel, tbl[i].lng}) begin
        n_fail++;
        $display("FAIL table row %0d: got %b %b %b %b required %b %b %b %b", i,
                 btn_level, btn_press, btn_release, btn_long,
                 tbl[i].level, tbl[i].press, tbl[i].rel, tbl[i].lng);
      end
    end
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

    // Bounce on ch1: 2-cycle toggles never qualify.
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step({2'b11, (i < 20) ? (((i / 2) % 2) == 1) : 1'b1, 1'b1}, 1'b1);
      if (btn_level[1] || btn_press[1] || btn_release[1]) seen = 1;
    end
    check_int("bounce_rejected", seen, 0);

    // Long press on ch2.
    press_edge = -1; long_edge = -1; long_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      step(4'b1011, 1'b1);
      if (btn_press[2] && press_edge < 0) press_edge = e;
      if (btn_long[2]) begin long_cnt++; long_edge = e; end
    end
    check_int("long_press_edge", press_edge, 6);
    check_int("long_pulse_edge", long_edge, 26);
    check_int("long_pulse_count", long_cnt, 1);
    rel_edge = -1;
    for (int e = 0; e < 10; e++) begin
      step(4'b1111, 1'b1);
      if (btn_release[2] && rel_edge < 0) rel_edge = e;
    end
    check_int("long_release_edge", rel_edge, 6);

    // Release glitch on ch3: 2-cycle high blip after acceptance.
    press_cnt = 0; rel_cnt = 0; seen = 0;
    for (int e = 0; e < 20; e++) begin
      step((e == 8 || e == 9) ? 4'b1111 : 4'b0111, 1'b1);
      if (btn_press[3]) press_cnt++;
      if (btn_release[3]) rel_cnt++;
      if (e >= 6 && !btn_level[3]) seen = 1;
    end
    check_int("glitch_press_count", press_cnt, 1);
    check_int("glitch_release_count", rel_cnt, 0);
    check_int("glitch_level_dropped", seen, 0);
    for (int e = 0; e < 10; e++) step(4'b1111, 1'b1);

    // Reset mid-debounce on ch0: reset at edge 3, acceptance restarts from edge 4.
    press_edge = -1; early = 0;
    for (int e = 0; e < 14; e++) begin
      step(4'b1110, (e == 3) ? 1'b0 : 1'b1);
      if (btn_press[0] && press_edge < 0) press_edge = e;
      if (e < 10 && (btn_press != 0 || btn_level != 0)) early = 1;
    end
    check_int("reset_mid_press_edge", press_edge, 10);
    check_int("reset_mid_no_early_pulse", early, 0);
    for (int e = 0; e < 10; e++) step(4'b1111, 1'b1);

    // Random stimulus with per-channel change rates and rare resets.
    rnd_raw = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, (4 << ch) - 1) == 0) rnd_raw[ch] = ~rnd_raw[ch];
      step(rnd_raw, ($urandom_range(0, 599) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions the raw board push-buttons before they reach the processor system's 4-bit button PIO input.
- Per channel: 2-FF synchronisation, polarity normalisation and counter-based debounce.
- Outputs per channel: a clean level (drives the PIO), one-cycle press/release pulses, and a one-cycle long-press pulse for software or LED logic.
- All channels are independent and share one clock.

Parameters:
- WIDTH, 4, number of button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a change (10 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50000000, held cycles after acceptance before btn_long fires (1 s at 50 MHz); must be >= 1.
- ACTIVE_LOW, 1, 1 = raw input low means pressed; 0 = raw high means pressed.

Ports:
- clk_clk  input  1  system clock, all logic on rising edge.
- reset_reset_n  input  1  reset, synchronous, active-low; sampled on clk_clk rising edge.
- btn_raw  input  WIDTH  asynchronous raw button pins.
- btn_level  output  WIDTH  debounced level, 1 = pressed; feeds button_external_connection_export.
- btn_press  output  WIDTH  one-cycle pulse on accepted press.
- btn_release  output  WIDTH  one-cycle pulse on accepted release.
- btn_long  output  WIDTH  one-cycle pulse when held LONG_CYCLES after acceptance.

Behaviour:
- Reset: reset_reset_n low at a clock edge clears all state.
  - All outputs 0, every FSM in IDLE, counters 0, long_done 0.
  - Synchroniser flops load the "released" value after normalisation.
  - Reset asserted mid-debounce or mid-hold aborts with no pulse.
- Synchroniser: two flops per bit, then inversion when ACTIVE_LOW=1; the result is sync (1 = pressed).
- Counter width: CNT_W = $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1); counter saturates, never wraps.
- FSM per channel:
  - IDLE: sync=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - sync=0 -> IDLE (bounce rejected, no output change).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, btn_level<=1, btn_press pulse, cnt<=0.
    - Otherwise cnt++.
  - PRESSED:
    - sync=0 -> RELEASE_WAIT, cnt<=0.
    - Otherwise, if !long_done: when cnt==LONG_CYCLES-1, btn_long pulse and long_done<=1; else cnt++.
  - RELEASE_WAIT:
    - sync=1 -> PRESSED, cnt<=0. btn_level stays 1; long_done is kept, so btn_long fires at most once per press.
    - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0, btn_release pulse, long_done<=0.
    - Otherwise cnt++.
- Latency: btn_level/btn_press change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples a stable new raw value. Release timing is symmetric.
- Pulses: registered, high for exactly one cycle, coincident with the btn_level edge.
  - btn_long is never asserted in the same cycle as btn_press or btn_release.
  - btn_long never fires after btn_level has returned to 0.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES restarts qualification and produces no output.
- Simultaneity: simultaneous events on different channels are fully independent; multiple bits of a pulse vector may be high together.

Decomposition:
- Package button_pkg:
  - State enum btn_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}, 2-bit encoding.
  - Helper function for CNT_W.
- Sub-module button_debounce_ch: one channel (synchroniser, FSM, counter, long_done, registered outputs).
  - Instantiated WIDTH times in a generate loop by button_debounce.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1):
- Reset: hold reset_reset_n=0 for 3 cycles with btn_raw=4'b0000 -> all outputs 0 during and after reset; no pulses for 2 cycles after release of reset while the raw lines stay driven.
- Clean press: drive btn_raw[0]=0 from edge 0, others 1 -> btn_level[0]=1 and btn_press[0]=1 at edge 6 (D+2); btn_press high 1 cycle only.
- Bounce rejection: btn_raw[1] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> btn_level[1], btn_press[1], btn_release[1] remain 0 throughout.
- Long press: hold btn_raw[2]=0 for 40 cycles -> btn_press[2] at edge 6; btn_long[2] single pulse at edge 26; no second pulse. On release, btn_release[2] fires 6 edges after raw returns to 1.
- Release glitch: btn_raw[3] pressed and accepted, then a 2-cycle high glitch -> btn_level[3] stays 1; no btn_release; no extra btn_press.
- Reset mid-debounce: btn_raw[0]=0, assert reset at edge 3 for 1 cycle, keep raw low -> no pulse before reset; press accepted at edge 4+6=10.
